// File: rtl/solver_job_ctrl.sv
// Job front-end for solver_datapath: loads c limbs, supervises z=z^2+c iterations, returns count/escape.
// Latency: limb write one cycle after its accept; first iter_start after FLUSH_CYCLES idle cycles past the last write.
// Backpressure: job_ready only in IDLE/LOAD; a held result (res_ready=0) freezes the block and blocks new jobs.
module solver_job_ctrl #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int NUM_LIMBS       = 3,
  parameter int ITER_BITS       = 16,
  parameter int FLUSH_CYCLES    = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  job_cre_limb,
  input  logic [LIMB_SIZE_BITS-1:0]  job_cim_limb,
  input  logic                       job_last,
  input  logic [ITER_BITS-1:0]       job_max_iter,
  output logic [LIMB_SIZE_BITS-1:0]  C_cre_limb,
  output logic [LIMB_SIZE_BITS-1:0]  C_cim_limb,
  output logic [LIMB_INDEX_BITS-1:0] C_limb_ind,
  output logic                       C_cre_wr_en,
  output logic                       C_cim_wr_en,
  output logic                       iter_start,
  output logic                       iter_first,
  input  logic                       iter_done,
  input  logic                       W_diverged,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ITER_BITS-1:0]       res_iter,
  output logic                       res_diverged,
  output logic                       busy
);

  localparam int FLUSH_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [LIMB_INDEX_BITS-1:0] LAST_IDX   = LIMB_INDEX_BITS'(NUM_LIMBS - 1);
  localparam logic [FLUSH_W-1:0]         FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_FLUSH, S_ISSUE, S_WAIT, S_RESULT
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [LIMB_INDEX_BITS-1:0] r_beat_idx, w_beat_idx_nxt;
  logic [FLUSH_W-1:0]         r_flush_cnt, w_flush_cnt_nxt;
  logic [ITER_BITS-1:0]       r_max_iter, w_max_iter_nxt;
  logic [ITER_BITS-1:0]       r_iter_cnt, w_iter_cnt_nxt;
  logic                       r_job_ready, w_job_ready_nxt;
  logic [LIMB_SIZE_BITS-1:0]  r_c_cre, w_c_cre_nxt;
  logic [LIMB_SIZE_BITS-1:0]  r_c_cim, w_c_cim_nxt;
  logic [LIMB_INDEX_BITS-1:0] r_c_ind, w_c_ind_nxt;
  logic                       r_c_wr_en, w_c_wr_en_nxt;
  logic                       r_iter_start, w_iter_start_nxt;
  logic                       r_iter_first, w_iter_first_nxt;
  logic                       r_res_valid, w_res_valid_nxt;
  logic [ITER_BITS-1:0]       r_res_iter, w_res_iter_nxt;
  logic                       r_res_diverged, w_res_diverged_nxt;
  logic                       r_busy, w_busy_nxt;

  logic                       w_accept;
  logic [LIMB_INDEX_BITS-1:0] w_load_idx;
  logic [ITER_BITS-1:0]       w_cnt_inc;

  assign w_accept  = job_valid && r_job_ready;
  assign w_cnt_inc = r_iter_cnt + 1'b1;

  // State and every output register; reset aborts any job immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_beat_idx     <= '0;
      r_flush_cnt    <= '0;
      r_max_iter     <= '0;
      r_iter_cnt     <= '0;
      r_job_ready    <= 1'b0;
      r_c_cre        <= '0;
      r_c_cim        <= '0;
      r_c_ind        <= '0;
      r_c_wr_en      <= 1'b0;
      r_iter_start   <= 1'b0;
      r_iter_first   <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_iter     <= '0;
      r_res_diverged <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_idx     <= w_beat_idx_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_max_iter     <= w_max_iter_nxt;
      r_iter_cnt     <= w_iter_cnt_nxt;
      r_job_ready    <= w_job_ready_nxt;
      r_c_cre        <= w_c_cre_nxt;
      r_c_cim        <= w_c_cim_nxt;
      r_c_ind        <= w_c_ind_nxt;
      r_c_wr_en      <= w_c_wr_en_nxt;
      r_iter_start   <= w_iter_start_nxt;
      r_iter_first   <= w_iter_first_nxt;
      r_res_valid    <= w_res_valid_nxt;
      r_res_iter     <= w_res_iter_nxt;
      r_res_diverged <= w_res_diverged_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  // Next state plus next output values; pulses default low, everything else holds.
  always_comb begin
    w_state_nxt        = r_state;
    w_beat_idx_nxt     = r_beat_idx;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_max_iter_nxt     = r_max_iter;
    w_iter_cnt_nxt     = r_iter_cnt;
    w_c_cre_nxt        = r_c_cre;
    w_c_cim_nxt        = r_c_cim;
    w_c_ind_nxt        = r_c_ind;
    w_c_wr_en_nxt      = 1'b0;
    w_iter_start_nxt   = 1'b0;
    w_iter_first_nxt   = 1'b0;
    w_res_valid_nxt    = r_res_valid;
    w_res_iter_nxt     = r_res_iter;
    w_res_diverged_nxt = r_res_diverged;
    w_load_idx         = (r_state == S_IDLE) ? '0 : r_beat_idx;

    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (r_state == S_IDLE) begin
            w_max_iter_nxt = job_max_iter;
            w_iter_cnt_nxt = '0;
          end
          w_c_cre_nxt   = job_cre_limb;
          w_c_cim_nxt   = job_cim_limb;
          w_c_ind_nxt   = w_load_idx;
          w_c_wr_en_nxt = 1'b1;
          // The top index always terminates; job_last past it cannot matter.
          if (w_load_idx == LAST_IDX) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = '0;
          end else if (job_last) begin
            w_state_nxt    = S_FILL;
            w_beat_idx_nxt = w_load_idx + 1'b1;
          end else begin
            w_state_nxt    = S_LOAD;
            w_beat_idx_nxt = w_load_idx + 1'b1;
          end
        end
      end
      S_FILL: begin
        // Zero the low-order limbs a short job did not supply.
        w_c_cre_nxt   = '0;
        w_c_cim_nxt   = '0;
        w_c_ind_nxt   = r_beat_idx;
        w_c_wr_en_nxt = 1'b1;
        if (r_beat_idx == LAST_IDX) begin
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = '0;
        end else begin
          w_beat_idx_nxt = r_beat_idx + 1'b1;
        end
      end
      S_FLUSH: begin
        // Count 0 is the last-write cycle itself, so FLUSH_CYCLES idle cycles follow it.
        if (r_flush_cnt == FLUSH_LAST) begin
          if (r_max_iter == '0) begin
            w_state_nxt        = S_RESULT;
            w_res_valid_nxt    = 1'b1;
            w_res_iter_nxt     = r_iter_cnt;
            w_res_diverged_nxt = 1'b0;
          end else begin
            w_state_nxt      = S_ISSUE;
            w_iter_start_nxt = 1'b1;
            w_iter_first_nxt = (r_iter_cnt == '0);
          end
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (iter_done) begin
          w_iter_cnt_nxt = w_cnt_inc;
          if (W_diverged || (w_cnt_inc == r_max_iter)) begin
            w_state_nxt        = S_RESULT;
            w_res_valid_nxt    = 1'b1;
            w_res_iter_nxt     = w_cnt_inc;
            w_res_diverged_nxt = W_diverged;
          end else begin
            w_state_nxt      = S_ISSUE;
            w_iter_start_nxt = 1'b1;
            w_iter_first_nxt = 1'b0;
          end
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          w_state_nxt     = S_IDLE;
          w_res_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_job_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign job_ready    = r_job_ready;
  assign C_cre_limb   = r_c_cre;
  assign C_cim_limb   = r_c_cim;
  assign C_limb_ind   = r_c_ind;
  assign C_cre_wr_en  = r_c_wr_en;
  assign C_cim_wr_en  = r_c_wr_en;
  assign iter_start   = r_iter_start;
  assign iter_first   = r_iter_first;
  assign res_valid    = r_res_valid;
  assign res_iter     = r_res_iter;
  assign res_diverged = r_res_diverged;
  assign busy         = r_busy;

endmodule

// File: tb/tb_solver_job_ctrl.sv
// Directed bench for solver_job_ctrl: load, fill, flush timing, iteration supervision, result handshake, reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// A cycle-accurate sequencer stand-in answers each iter_start with iter_done three cycles later.
module tb_solver_job_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_cre_limb = '0;
  logic [7:0]  job_cim_limb = '0;
  logic        job_last = 1'b0;
  logic [15:0] job_max_iter = '0;
  logic [7:0]  C_cre_limb;
  logic [7:0]  C_cim_limb;
  logic [5:0]  C_limb_ind;
  logic        C_cre_wr_en;
  logic        C_cim_wr_en;
  logic        iter_start;
  logic        iter_first;
  logic        iter_done = 1'b0;
  logic        W_diverged = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_iter;
  logic        res_diverged;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  solver_job_ctrl dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_cre_limb(job_cre_limb), .job_cim_limb(job_cim_limb),
    .job_last(job_last), .job_max_iter(job_max_iter),
    .C_cre_limb(C_cre_limb), .C_cim_limb(C_cim_limb), .C_limb_ind(C_limb_ind),
    .C_cre_wr_en(C_cre_wr_en), .C_cim_wr_en(C_cim_wr_en),
    .iter_start(iter_start), .iter_first(iter_first),
    .iter_done(iter_done), .W_diverged(W_diverged),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_iter(res_iter), .res_diverged(res_diverged), .busy(busy)
  );

  // Drives one job back to back; limb 0 is the top byte of cre/cim.
  task automatic send_job(input logic [23:0] cre, input logic [23:0] cim, input int nbeats,
                          input logic [15:0] maxit, output bit ok);
    ok = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      job_valid    = 1'b1;
      job_cre_limb = cre[8*(2-b) +: 8];
      job_cim_limb = cim[8*(2-b) +: 8];
      job_last     = (b == nbeats - 1);
      job_max_iter = maxit;
      for (int n = 0; n < 50 && job_ready !== 1'b1; n++) @(negedge clock);
      if (job_ready !== 1'b1) ok = 1'b0;
      @(negedge clock);
    end
    job_valid = 1'b0;
    job_last  = 1'b0;
  endtask

  // Sequencer stand-in: answers iter_start after 3 cycles; diverges on start number div_at (0 = never).
  // noise drives W_diverged high on cycles without iter_done. stop_starts > 0 returns on that start.
  task automatic serve(input int div_at, input bit noise, input int budget, input int stop_starts,
                       output int starts, output int firsts, output bit got);
    int cd;
    cd = -1; starts = 0; firsts = 0; got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      iter_done  = 1'b0;
      W_diverged = 1'b0;
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (iter_start === 1'b1) begin
        starts++;
        if (iter_first === 1'b1) firsts++;
        cd = 2;
        if (stop_starts > 0 && starts == stop_starts) break;
      end
      W_diverged = noise;
      if (cd == 0) begin
        iter_done  = 1'b1;
        W_diverged = (starts == div_at);
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      @(negedge clock);
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++; if (job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b want 0", job_ready); else n_pass++;
    n_checks++; if ({busy, res_valid, iter_start, C_cre_wr_en, C_cim_wr_en} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {busy, res_valid, iter_start, C_cre_wr_en, C_cim_wr_en}); else n_pass++;
    n_checks++; if ({res_iter, C_limb_ind, C_cre_limb} !== 30'b0)
      $display("FAIL reset_fields: res_iter %h ind %h cre %h want 0", res_iter, C_limb_ind, C_cre_limb); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (job_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", job_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
  endtask

  // c = 0.5 - 1.5i, three beats, then check flush spacing.
  task automatic test_full_load();
    logic [7:0] cre_t [3];
    logic [7:0] cim_t [3];
    int gap, starts, firsts;
    bit bad, got, extra_wr;
    cre_t = '{8'h00, 8'h80, 8'h00};
    cim_t = '{8'hfe, 8'h80, 8'h00};
    bad = 1'b0;
    job_max_iter = 16'd1;
    for (int b = 0; b < 3; b++) begin
      job_valid = 1'b1; job_cre_limb = cre_t[b]; job_cim_limb = cim_t[b]; job_last = 1'b0;
      @(negedge clock);
      if (C_cre_wr_en !== 1'b1 || C_cim_wr_en !== 1'b1 || C_limb_ind !== 6'(b) ||
          C_cre_limb !== cre_t[b] || C_cim_limb !== cim_t[b]) bad = 1'b1;
    end
    job_valid = 1'b0;
    n_checks++; if (bad) $display("FAIL full_load_writes: last ind %0d cre %h cim %h", C_limb_ind, C_cre_limb, C_cim_limb); else n_pass++;
    n_checks++; if (job_ready !== 1'b0) $display("FAIL full_load_ready_drop: got %b want 0", job_ready); else n_pass++;
    // Five idle cycles separate the last write cycle from the iter_start cycle.
    gap = 0; extra_wr = 1'b0;
    while (iter_start !== 1'b1 && gap < 20) begin
      @(negedge clock);
      gap++;
      if (C_cre_wr_en === 1'b1) extra_wr = 1'b1;
    end
    n_checks++; if (gap != 6) $display("FAIL full_load_flush_gap: got %0d cycles want 6", gap); else n_pass++;
    n_checks++; if (extra_wr) $display("FAIL full_load_wr_fall: got wr_en after last write want 0"); else n_pass++;
    n_checks++; if (iter_first !== 1'b1) $display("FAIL full_load_iter_first: got %b want 1", iter_first); else n_pass++;
    serve(0, 1'b0, 100, 0, starts, firsts, got);
    n_checks++; if (got !== 1'b1 || res_iter !== 16'd1 || res_diverged !== 1'b0)
      $display("FAIL full_load_result: got valid %b iter %0d div %b want 1 1 0", got, res_iter, res_diverged); else n_pass++;
    take_result();
  endtask

  task automatic test_short_job();
    int gap, starts, firsts;
    bit got, ready_hi;
    job_max_iter = 16'd2;
    job_valid = 1'b1; job_cre_limb = 8'h01; job_cim_limb = 8'h11; job_last = 1'b0;
    @(negedge clock);
    job_cre_limb = 8'h40; job_cim_limb = 8'h22; job_last = 1'b1;
    @(negedge clock);
    job_valid = 1'b0; job_last = 1'b0;
    n_checks++; if (C_limb_ind !== 6'd1 || C_cre_limb !== 8'h40 || C_cim_limb !== 8'h22 || C_cre_wr_en !== 1'b1)
      $display("FAIL short_ind1: got ind %0d %h/%h wr %b want 1 40/22 1", C_limb_ind, C_cre_limb, C_cim_limb, C_cre_wr_en); else n_pass++;
    ready_hi = (job_ready !== 1'b0);
    @(negedge clock);
    n_checks++; if (C_limb_ind !== 6'd2 || C_cre_limb !== 8'h00 || C_cim_limb !== 8'h00 || C_cim_wr_en !== 1'b1)
      $display("FAIL short_fill: got ind %0d %h/%h wr %b want 2 00/00 1", C_limb_ind, C_cre_limb, C_cim_limb, C_cim_wr_en); else n_pass++;
    gap = 0;
    while (iter_start !== 1'b1 && gap < 20) begin
      if (job_ready !== 1'b0) ready_hi = 1'b1;
      @(negedge clock);
      gap++;
    end
    n_checks++; if (ready_hi) $display("FAIL short_ready_low: got job_ready 1 in FILL/FLUSH want 0"); else n_pass++;
    n_checks++; if (gap != 6) $display("FAIL short_flush_gap: got %0d cycles want 6", gap); else n_pass++;
    serve(0, 1'b0, 100, 0, starts, firsts, got);
    n_checks++; if (got !== 1'b1 || res_iter !== 16'd2) $display("FAIL short_result: got valid %b iter %0d want 1 2", got, res_iter); else n_pass++;
    take_result();
  endtask

  task automatic test_divergence();
    int starts, firsts;
    bit ok, got;
    send_job(24'h00c000, 24'h004000, 3, 16'd10, ok);
    serve(3, 1'b0, 300, 0, starts, firsts, got);
    n_checks++; if (!ok || got !== 1'b1) $display("FAIL div_handshake: got ok %b valid %b want 1 1", ok, got); else n_pass++;
    n_checks++; if (res_iter !== 16'd3 || res_diverged !== 1'b1)
      $display("FAIL div_result: got iter %0d div %b want 3 1", res_iter, res_diverged); else n_pass++;
    n_checks++; if (starts != 3 || firsts != 1)
      $display("FAIL div_starts: got %0d starts %0d first want 3 1", starts, firsts); else n_pass++;
    take_result();
  endtask

  task automatic test_limit();
    int starts, firsts;
    bit ok, got;
    send_job(24'h000000, 24'h000000, 3, 16'd4, ok);
    serve(0, 1'b1, 300, 0, starts, firsts, got);
    n_checks++; if (!ok || got !== 1'b1 || res_iter !== 16'd4 || res_diverged !== 1'b0)
      $display("FAIL limit4_result: got valid %b iter %0d div %b want 1 4 0", got, res_iter, res_diverged); else n_pass++;
    n_checks++; if (starts != 4 || firsts != 1) $display("FAIL limit4_starts: got %0d/%0d want 4/1", starts, firsts); else n_pass++;
    take_result();
    send_job(24'h010203, 24'h040506, 3, 16'd0, ok);
    serve(0, 1'b0, 100, 0, starts, firsts, got);
    n_checks++; if (!ok || got !== 1'b1 || res_iter !== 16'd0 || res_diverged !== 1'b0)
      $display("FAIL limit0_result: got valid %b iter %0d div %b want 1 0 0", got, res_iter, res_diverged); else n_pass++;
    n_checks++; if (starts != 0) $display("FAIL limit0_no_start: got %0d starts want 0", starts); else n_pass++;
    take_result();
  endtask

  task automatic test_backpressure();
    int starts, firsts;
    bit ok, got, moved;
    send_job(24'h00ff00, 24'h000100, 3, 16'd2, ok);
    serve(0, 1'b0, 200, 0, starts, firsts, got);
    n_checks++; if (!ok || got !== 1'b1) $display("FAIL bp_result_arrives: got ok %b valid %b want 1 1", ok, got); else n_pass++;
    job_valid = 1'b1; job_cre_limb = 8'h7f; job_cim_limb = 8'h01; job_last = 1'b1; job_max_iter = 16'd0;
    moved = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (res_valid !== 1'b1 || res_iter !== 16'd2 || res_diverged !== 1'b0 ||
          job_ready !== 1'b0 || C_cre_wr_en !== 1'b0) moved = 1'b1;
      @(negedge clock);
    end
    n_checks++; if (moved) $display("FAIL bp_hold: got valid %b iter %0d ready %b wr %b want 1 2 0 0", res_valid, res_iter, job_ready, C_cre_wr_en); else n_pass++;
    take_result();
    n_checks++; if (res_valid !== 1'b0 || job_ready !== 1'b1)
      $display("FAIL bp_handshake: got valid %b ready %b want 0 1", res_valid, job_ready); else n_pass++;
    n_checks++; if (C_cre_wr_en !== 1'b0) $display("FAIL bp_no_early_accept: got wr %b want 0", C_cre_wr_en); else n_pass++;
    @(negedge clock);
    job_valid = 1'b0; job_last = 1'b0;
    n_checks++; if (C_cre_wr_en !== 1'b1 || C_limb_ind !== 6'd0 || C_cre_limb !== 8'h7f || job_ready !== 1'b0)
      $display("FAIL bp_next_accept: got wr %b ind %0d cre %h ready %b want 1 0 7f 0", C_cre_wr_en, C_limb_ind, C_cre_limb, job_ready); else n_pass++;
    serve(0, 1'b0, 100, 0, starts, firsts, got);
    n_checks++; if (got !== 1'b1 || res_iter !== 16'd0 || starts != 0)
      $display("FAIL bp_next_result: got valid %b iter %0d starts %0d want 1 0 0", got, res_iter, starts); else n_pass++;
    take_result();
  endtask

  task automatic test_reset_mid();
    int starts, firsts;
    bit ok, got;
    send_job(24'h00a000, 24'h001000, 3, 16'd10, ok);
    serve(0, 1'b0, 200, 3, starts, firsts, got);
    n_checks++; if (!ok || starts != 3) $display("FAIL rst_reach_wait: got ok %b starts %0d want 1 3", ok, starts); else n_pass++;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({busy, job_ready, iter_start, iter_first, res_valid, C_cre_wr_en} !== 6'b0)
      $display("FAIL rst_async_outputs: got %b want 000000", {busy, job_ready, iter_start, iter_first, res_valid, C_cre_wr_en}); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_recover: got ready %b busy %b want 1 0", job_ready, busy); else n_pass++;
    send_job(24'h00a000, 24'h001000, 3, 16'd3, ok);
    serve(0, 1'b0, 200, 0, starts, firsts, got);
    n_checks++; if (!ok || got !== 1'b1 || res_iter !== 16'd3 || res_diverged !== 1'b0)
      $display("FAIL rst_next_result: got valid %b iter %0d div %b want 1 3 0", got, res_iter, res_diverged); else n_pass++;
    n_checks++; if (starts != 3 || firsts != 1) $display("FAIL rst_next_starts: got %0d/%0d want 3/1", starts, firsts); else n_pass++;
    take_result();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_short_job();
    test_divergence();
    test_limit();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/solver_job_ctrl.md
Name: solver_job_ctrl

Overview:
Job front-end and iteration supervisor that sits directly upstream of solver_datapath. It accepts one point c (real and imaginary limbs) per job over a valid/ready stream and writes those limbs into the datapath's cre/cim registers. It then issues one iteration at a time to the iteration schedule sequencer, counts iterations until the datapath's W_diverged flag fires or the per-job limit is reached, and returns the result over a valid/ready stream.

Parameters:
LIMB_INDEX_BITS, 6, width of limb index
LIMB_SIZE_BITS, 8, bits per limb
NUM_LIMBS, 3, limbs per operand; index 0 = most significant (integer) limb
ITER_BITS, 16, width of iteration counters
FLUSH_CYCLES, 5, idle cycles after the last cre/cim write, before the first iteration

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low; asserted when 0
job_valid  in  1  limb beat valid
job_ready  out  1  limb beat accepted when job_valid && job_ready
job_cre_limb  in  LIMB_SIZE_BITS  real limb, most significant first
job_cim_limb  in  LIMB_SIZE_BITS  imaginary limb
job_last  in  1  final limb of job
job_max_iter  in  ITER_BITS  iteration limit, sampled on first beat only
C_cre_limb  out  LIMB_SIZE_BITS  to datapath
C_cim_limb  out  LIMB_SIZE_BITS  to datapath
C_limb_ind  out  LIMB_INDEX_BITS  to datapath
C_cre_wr_en  out  1  to datapath
C_cim_wr_en  out  1  to datapath
iter_start  out  1  one-cycle pulse, requests one z=z^2+c pass from sequencer
iter_first  out  1  valid with iter_start; 1 = z treated as 0
iter_done  in  1  one-cycle pulse, sequencer's final z write retired
W_diverged  in  1  datapath divergence flag, meaningful when iter_done=1
res_valid  out  1  result valid
res_ready  in  1  result accepted when res_valid && res_ready
res_iter  out  ITER_BITS  iterations completed
res_diverged  out  1  1 = escaped, 0 = limit reached
busy  out  1  state != IDLE

Behaviour:
- All outputs registered. While reset=0: state IDLE, all outputs 0, counters 0. job_ready goes to 1 on the first rising edge after reset is released.
- States: IDLE, LOAD, FILL, FLUSH, ISSUE, WAIT, RESULT. job_ready is 1 only in IDLE/LOAD. It drops on the edge that accepts the terminating beat.
- Load: beat k (k = 0, 1, ...) accepted at edge t. At edge t+1: C_limb_ind=k, C_cre_limb/C_cim_limb = beat data, C_cre_wr_en=C_cim_wr_en=1. Write enables fall the cycle after the last write. No bubbles are required between beats.
- The first beat captures job_max_iter, clears iter_cnt, and moves IDLE -> LOAD.
- A beat terminates the load if job_last=1 or k=NUM_LIMBS-1; job_last is ignored beyond index NUM_LIMBS-1.
- FILL: if terminated at k<NUM_LIMBS-1, indices k+1..NUM_LIMBS-1 are written with zero limbs, one per cycle, back-to-back after the last real write.
- FLUSH: hold FLUSH_CYCLES cycles after the last write enable, then go to ISSUE.
- max_iter=0: go FLUSH -> RESULT with res_iter=0, res_diverged=0, and no iter_start.
- ISSUE: one-cycle iter_start=1, iter_first=(iter_cnt==0), then WAIT.
- WAIT: on iter_done, iter_cnt increments.
  - If W_diverged=1 in that same cycle -> RESULT, diverged=1.
  - Else if the new iter_cnt==max_iter -> RESULT, diverged=0.
  - Else -> ISSUE. Minimum gap from iter_done to the next iter_start is 1 cycle.
- iter_done outside WAIT is ignored. W_diverged without iter_done is ignored.
- RESULT: res_valid=1; res_iter=iter_cnt and res_diverged are held stable until accepted. On acceptance, res_valid falls next cycle -> IDLE, and job_ready=1 the same cycle. No new job is accepted before the result is taken.
- iter_cnt cannot wrap, because it stops at max_iter ≤ 2^ITER_BITS-1.
- Reset mid-job (any state): immediately abort, with outputs as reset. Partially written cre/cim is not cleaned and is overwritten by the next job.

Test Plan:
- Full load, 3 beats back-to-back: cre 00,80,00 and cim fe,80,00 (c=0.5-1.5i) -> three consecutive cycles of wr_en=1 at ind 0,1,2 with matching limbs; job_ready low from the 3rd accept; first iter_start (iter_first=1) exactly 5 cycles after the last wr_en cycle.
- Short job: 2 beats cre 01,40 with job_last on the second -> ind 2 written with 00/00 the cycle after ind 1; job_ready=0 throughout FILL/FLUSH.
- Divergence: max_iter=10; sequencer returns iter_done with W_diverged=1 on the 3rd iteration -> res_iter=3, res_diverged=1; exactly 3 iter_start pulses, only the first with iter_first=1.
- Limit: max_iter=4, W_diverged always 0 -> res_iter=4, res_diverged=0. max_iter=0 -> res_iter=0 with no iter_start.
- Backpressure: res_ready held 0 for 7 cycles -> res_valid and fields stable; a job_valid presented meanwhile is not accepted until the cycle after the handshake.
- Reset pulse (reset=0) during WAIT with 2 iterations done -> all outputs 0 asynchronously; next job starts cleanly with iter_first=1 and res_iter counting from 0.
